// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: supervises a UART receiver. Completed octets are moved into a
// small FIFO and acknowledged. A receiver error pulses the receiver's
// active-low reset for RECOVER_CYCLES clocks and is counted. Holding off the
// acknowledge while the FIFO is full is how backpressure reaches the receiver.
module uart_rx_ctrl #(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic       uart_reset_o,
  input  logic [7:0] uart_data_i,
  input  logic       uart_ready_i,
  output logic       uart_ack_o,
  input  logic       uart_error_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] err_count_o,
  output logic       ovr_o,
  input  logic       clear_i
);

  localparam int         PtrW    = $clog2(DEPTH);
  localparam int         CntW    = PtrW + 1;
  localparam logic [7:0] RecLoad = 8'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        recCnt_q, recCnt_d;
  logic              ack_q, ack_d;
  logic              uartRst_q, uartRst_d;
  logic [7:0]        errCount_q, errCount_d;
  logic              ovr_q, ovr_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [7:0]        head_q, head_d;
  logic [7:0]        mem [DEPTH];

  logic              push;
  logic              pop;
  logic              errEntry;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [PtrW-1:0]   rdNext;

  assign fifoFull  = (count_q == CntW'(DEPTH));
  assign fifoEmpty = (count_q == '0);
  assign pop       = ready_i && !fifoEmpty;
  assign rdNext    = rdPtr_q + PtrW'(1);

  // Control FSM: errors win over new octets; a full FIFO withholds the ack.
  always_comb begin
    state_d  = state_q;
    recCnt_d = recCnt_q;
    push     = 1'b0;
    errEntry = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (uart_error_i) begin
          state_d  = RECOVER;
          recCnt_d = RecLoad;
          errEntry = 1'b1;
        end else if (uart_ready_i && !fifoFull) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      RECOVER: begin
        if (recCnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          recCnt_d = recCnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ack_d     = (state_d == ACK);
    uartRst_d = (state_d != RECOVER);
  end

  // FIFO bookkeeping: pointers, occupancy and the registered head byte.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    head_d  = head_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PtrW'(1);
    end
    if (pop) begin
      rdPtr_d = rdNext;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      if (count_q > CntW'(1)) begin
        head_d = mem[rdNext];
      end else if (push) begin
        head_d = uart_data_i;
      end else begin
        head_d = 8'd0;
      end
    end else if (fifoEmpty && push) begin
      head_d = uart_data_i;
    end
  end

  // Error statistics: a clear is applied first so a coincident error counts as one.
  always_comb begin
    errCount_d = errCount_q;
    ovr_d      = ovr_q;
    if (clear_i) begin
      errCount_d = 8'd0;
      ovr_d      = 1'b0;
    end
    if (errEntry) begin
      if (errCount_d != 8'hFF) begin
        errCount_d = errCount_d + 8'd1;
      end
      ovr_d = ovr_d | fifoFull;
    end
  end

  // State and control registers; reset parks the block in recovery.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RECOVER;
      recCnt_q   <= RecLoad;
      ack_q      <= 1'b0;
      uartRst_q  <= 1'b0;
      errCount_q <= 8'd0;
      ovr_q      <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      head_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      recCnt_q   <= recCnt_d;
      ack_q      <= ack_d;
      uartRst_q  <= uartRst_d;
      errCount_q <= errCount_d;
      ovr_q      <= ovr_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      head_q     <= head_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= uart_data_i;
    end
  end

  assign uart_reset_o = uartRst_q;
  assign uart_ack_o   = ack_q;
  assign data_o       = head_q;
  assign valid_o      = !fifoEmpty;
  assign err_count_o  = errCount_q;
  assign ovr_o        = ovr_q;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The parameter DEPTH SHALL default to 4 and set the FIFO depth in bytes; legal values are powers of two from 2 to 16.
REQ-002 The parameter RECOVER_CYCLES SHALL default to 4 and set the number of clocks uart_reset_o is held low after an error; legal values are 1 to 255.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all transitions occur on posedge clk.
REQ-004 Port reset SHALL be an input, 1 bit wide, and is the asynchronous, active-low reset.
REQ-005 Port uart_reset_o SHALL be an output, 1 bit wide, and drives the active-low reset of the attached UART receiver.
REQ-006 Port uart_data_i SHALL be an input, 8 bits wide, and carries the receiver octet, valid while uart_ready_i is high.
REQ-007 Port uart_ready_i SHALL be an input, 1 bit wide, and indicates that the receiver holds a complete octet.
REQ-008 Port uart_ack_o SHALL be an output, 1 bit wide, and releases the receiver's held octet.
REQ-009 Port uart_error_i SHALL be an input, 1 bit wide, and is the sticky error from the receiver (framing error or overrun).
REQ-010 Port data_o SHALL be an output, 8 bits wide, and presents the FIFO head byte.
REQ-011 Port valid_o SHALL be an output, 1 bit wide, and indicates that the FIFO is non-empty.
REQ-012 Port ready_i SHALL be an input, 1 bit wide; the consumer pops the head when valid_o and ready_i are both high.
REQ-013 Port err_count_o SHALL be an output, 8 bits wide, and is a saturating count of receiver errors.
REQ-014 Port ovr_o SHALL be an output, 1 bit wide, and is a sticky flag: an error was seen while the FIFO was full.
REQ-015 Port clear_i SHALL be an input, 1 bit wide, and a one-cycle pulse on it clears err_count_o and ovr_o.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACK and RECOVER.
REQ-017 In IDLE with uart_error_i high, the FSM SHALL go to RECOVER, load the recovery counter with RECOVER_CYCLES-1, and drive uart_reset_o low from the next cycle; uart_error_i takes priority over uart_ready_i.
REQ-018 In IDLE with uart_ready_i high, uart_error_i low and the FIFO not full, the FSM SHALL push uart_data_i into the FIFO, drive uart_ack_o high on the next cycle, and go to ACK.
REQ-019 In IDLE with uart_ready_i high and the FIFO full, the FSM SHALL not acknowledge and SHALL remain in IDLE, leaving the octet held in the receiver (backpressure).
REQ-020 ACK SHALL last exactly one cycle with uart_ack_o high, then return to IDLE with uart_ack_o low; uart_ready_i is ignored during ACK.
REQ-021 In RECOVER, uart_reset_o SHALL be low and the counter SHALL decrement each cycle; at count 0 the FSM goes to IDLE and uart_reset_o goes high on the next cycle, so the low pulse lasts exactly RECOVER_CYCLES clocks.
REQ-022 The FIFO SHALL be synchronous and first-in first-out; data_o is registered head data, valid on the same cycle valid_o is high.
REQ-023 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-024 A pop on an empty FIFO SHALL be ignored; a push on a full FIFO never occurs (REQ-019).
REQ-025 Pointers SHALL wrap modulo DEPTH, and occupancy SHALL range from 0 to DEPTH inclusive.
REQ-026 On entry to RECOVER, err_count_o SHALL increment, saturating at 255.
REQ-027 On entry to RECOVER, ovr_o SHALL be set if the FIFO is full in that cycle.
REQ-028 If clear_i and an error entry coincide, err_count_o SHALL become 1 and ovr_o SHALL take the value of the new event (clear first, then count).
REQ-029 FIFO contents SHALL be unaffected by RECOVER, and the consumer may keep popping during it.
REQ-030 The latency from uart_ready_i high (FIFO empty) to valid_o high SHALL be 1 clock.

Reset
REQ-031 While reset is low, the block SHALL hold: FIFO empty, valid_o=0, data_o=0, uart_ack_o=0, err_count_o=0, ovr_o=0, uart_reset_o=0, state RECOVER with counter RECOVER_CYCLES-1.
REQ-032 After reset is released, uart_reset_o SHALL stay low for RECOVER_CYCLES clocks, then rise; err_count_o SHALL not count this recovery.
REQ-033 A reset asserted mid-operation SHALL discard all FIFO contents and any in-progress ACK immediately, without waiting for a clock.

Verification
REQ-034 Release reset with RECOVER_CYCLES=4 -> uart_reset_o is low for exactly 4 clocks, and err_count_o=0.
REQ-035 Present uart_ready_i=1 with uart_data_i=0x5A, FIFO empty -> uart_ack_o is high for exactly 1 cycle; the next cycle gives valid_o=1 and data_o=0x5A.
REQ-036 Push 4 bytes 0x01..0x04 with ready_i=0, then present a 5th -> no ack is given; raise ready_i -> the bytes pop in order 0x01..0x04, then the 5th is acked.
REQ-037 With the FIFO full, pulse uart_error_i -> uart_reset_o is low for 4 clocks, err_count_o=1, ovr_o=1; then pulse clear_i -> both return to 0.
REQ-038 Apply 260 error events -> err_count_o saturates at 255; an error coincident with clear_i -> err_count_o=1.
REQ-039 Assert reset with 3 bytes queued -> valid_o=0 asynchronously; after release the FIFO is empty.
